// File: rtl/mult_accum_pkg.sv
// Shared definitions for the mult_accum product accumulator: FSM encoding,
// default group length and counter sizing helper.
package mult_accum_pkg;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam int LEN_DEFAULT = 4;

    function automatic int cnt_width(input int len);
        return $clog2(len);
    endfunction

endpackage

// File: rtl/mult_accum_if.sv
// Product input / result output bundle between multiplier, accumulator and sink.
// master = upstream driver side, slave = accumulator side.
interface mult_accum_if #(
    parameter int width = 8,
    parameter int ACC_W = 2*width + 4
);
    logic                    prod_valid;
    logic signed [2*width-1:0] prod;
    logic                    res_valid;
    logic                    res_ready;
    logic signed [ACC_W-1:0] res;

    modport master (
        output prod_valid,
        output prod,
        output res_ready,
        input  res_valid,
        input  res
    );

    modport slave (
        input  prod_valid,
        input  prod,
        input  res_ready,
        output res_valid,
        output res
    );
endinterface

// File: rtl/mult_accum_acc_sat_add.sv
// Signed ACC_W-bit adder with overflow detect; clamps to the signed range
// when MULT_ACCUM_SAT_EN is defined, otherwise wraps.
module acc_sat_add #(
    parameter int ACC_W = 20
) (
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [ACC_W-1:0] b,
    output logic signed [ACC_W-1:0] sum,
    output logic                    ovf
);
    logic signed [ACC_W-1:0] raw;

    always_comb begin
        raw = a + b;
        // Overflow only when both operands share a sign the result lacks.
        ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
`ifdef MULT_ACCUM_SAT_EN
        if (ovf) begin
            sum = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                             : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            sum = raw;
        end
`else
        sum = raw;
`endif
    end

endmodule

// File: rtl/mult_accum.sv
// Accumulates LEN signed products into one result with a valid/ready output.
// Optional clamp on overflow: define MULT_ACCUM_SAT_EN.
module mult_accum
    import mult_accum_pkg::*;
#(
    parameter int width = 8,
    parameter int LEN   = LEN_DEFAULT,
    parameter int ACC_W = 2*width + 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    mult_accum_if.slave  bus,
    output logic         busy,
    output logic         ovf,
    output logic         drop
);
    localparam int CNT_W = cnt_width(LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    state_t                  state_reg, state_next;
    logic signed [ACC_W-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic signed [ACC_W-1:0] res_reg, res_next;
    logic                    res_valid_reg, res_valid_next;
    logic                    ovf_reg, ovf_next;
    logic                    drop_reg, drop_next;

    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum;
    logic                    add_ovf;

    assign prod_ext = ACC_W'(bus.prod);

    acc_sat_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .a   (acc_reg),
        .b   (prod_ext),
        .sum (sum),
        .ovf (add_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_ACC;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            res_reg       <= '0;
            res_valid_reg <= 1'b0;
            ovf_reg       <= 1'b0;
            drop_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            res_reg       <= res_next;
            res_valid_reg <= res_valid_next;
            ovf_reg       <= ovf_next;
            drop_reg      <= drop_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        res_next       = res_reg;
        res_valid_next = res_valid_reg;
        ovf_next       = ovf_reg;
        drop_next      = 1'b0;

        if (clr) begin
            // res keeps its last value; only the control/accumulation state clears.
            state_next     = ST_ACC;
            acc_next       = '0;
            cnt_next       = '0;
            res_valid_next = 1'b0;
            ovf_next       = 1'b0;
        end else begin
            case (state_reg)
                ST_ACC: begin
                    if (bus.prod_valid) begin
                        ovf_next = ovf_reg | add_ovf;
                        if (cnt_reg == CNT_LAST) begin
                            res_next       = sum;
                            res_valid_next = 1'b1;
                            acc_next       = '0;
                            cnt_next       = '0;
                            state_next     = ST_HOLD;
                        end else begin
                            acc_next = sum;
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.res_ready) begin
                        res_valid_next = 1'b0;
                        state_next     = ST_ACC;
                        // A product arriving on the handshake cycle opens the next group.
                        if (bus.prod_valid) begin
                            acc_next = prod_ext;
                            cnt_next = CNT_W'(1);
                        end
                    end else if (bus.prod_valid) begin
                        drop_next = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_ACC;
                end
            endcase
        end
    end

    assign bus.res       = res_reg;
    assign bus.res_valid = res_valid_reg;
    assign busy          = (cnt_reg != '0);
    assign ovf           = ovf_reg;
    assign drop          = drop_reg;

endmodule

// File: tb/tb_mult_accum.sv
// Directed self-checking bench for mult_accum (width=8, LEN=4, ACC_W=16).
// Expected values are hand-computed; saturating expectations follow MULT_ACCUM_SAT_EN.
module tb_mult_accum;

    logic clk;
    logic rst_n;
    logic clr;
    logic busy;
    logic ovf;
    logic drop;

    int n_vec  = 0;
    int n_miss = 0;

    mult_accum_if #(.width(8), .ACC_W(16)) bus ();

    mult_accum #(
        .width (8),
        .LEN   (4),
        .ACC_W (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus),
        .busy  (busy),
        .ovf   (ovf),
        .drop  (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, required %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int p);
        bus.prod_valid = 1'b1;
        bus.prod       = 16'(p);
        step();
        bus.prod_valid = 1'b0;
    endtask

    task automatic send4(input int p0, input int p1, input int p2, input int p3);
        send(p0);
        send(p1);
        send(p2);
        send(p3);
    endtask

    initial begin
        rst_n          = 1'b0;
        clr            = 1'b0;
        bus.prod_valid = 1'b0;
        bus.prod       = '0;
        bus.res_ready  = 1'b1;
        step();
        step();
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res", bus.res, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        check("rst_drop", drop, 0);
        rst_n = 1'b1;
        step();

        // Basic group, back-to-back products
        send(100);
        check("basic_busy_after_1", busy, 1);
        send(-50);
        send(25);
        send(3);
        check("basic_res_valid", bus.res_valid, 1);
        check("basic_res", bus.res, 78);
        check("basic_ovf", ovf, 0);
        check("basic_busy_after_4", busy, 0);
        step();
        check("basic_valid_one_cycle", bus.res_valid, 0);

        // Overflow: 4 x 16384 in a 16-bit accumulator
        send4(16384, 16384, 16384, 16384);
`ifdef MULT_ACCUM_SAT_EN
        check("ovf_res", bus.res, 32767);
`else
        check("ovf_res", bus.res, 0);
`endif
        check("ovf_flag", ovf, 1);
        step();
        check("ovf_sticky", ovf, 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("ovf_cleared_by_clr", ovf, 0);

        // Backpressure: product during HOLD is dropped
        bus.res_ready = 1'b0;
        send4(10, 20, 30, 40);
        check("bp_res", bus.res, 100);
        step();
        step();
        check("bp_res_stable", bus.res, 100);
        check("bp_valid_held", bus.res_valid, 1);
        send(7);
        check("bp_drop_pulse", drop, 1);
        check("bp_busy_after_drop", busy, 0);
        step();
        check("bp_drop_one_cycle", drop, 0);
        check("bp_res_after_drop", bus.res, 100);
        step();
        bus.res_ready = 1'b1;
        step();
        check("bp_handshake", bus.res_valid, 0);
        send4(1, 1, 1, 1);
        check("bp_next_group_no_7", bus.res, 4);
        step();

        // Handshake and product in the same cycle
        bus.res_ready = 1'b0;
        send4(5, 5, 5, 5);
        check("hs_res", bus.res, 20);
        step();
        bus.res_ready = 1'b1;
        send(-9);
        check("hs_valid_cleared", bus.res_valid, 0);
        check("hs_busy", busy, 1);
        check("hs_no_drop", drop, 0);
        send(1);
        send(2);
        send(3);
        check("hs_res_includes_neg9", bus.res, -3);
        check("hs_res_valid", bus.res_valid, 1);
        step();

        // clr mid-group
        send(50);
        send(60);
        check("clr_busy_before", busy, 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_busy_after", busy, 0);
        check("clr_ovf_after", ovf, 0);
        send4(1, 2, 3, 4);
        check("clr_next_group", bus.res, 10);
        step();

        // Reset while a result is pending
        bus.res_ready = 1'b0;
        send4(2, 2, 2, 2);
        check("rh_res_before", bus.res, 8);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rh_res_valid", bus.res_valid, 0);
        check("rh_res", bus.res, 0);
        bus.res_ready = 1'b1;
        send4(100, -50, 25, 3);
        check("rh_regroup_res", bus.res, 78);
        check("rh_regroup_valid", bus.res_valid, 1);
        step();
        check("rh_regroup_valid_drop", bus.res_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mult_accum.md
MULT_ACCUM -- requirements
Module: mult_accum

Interface
REQ-001 Parameter: width, default 8, operand width of the upstream multiplier; the product is 2*width bits, signed.
REQ-002 Parameter: LEN, default 4, number of products per accumulated result; legal range 2..256.
REQ-003 Parameter: ACC_W, default 2*width+4, accumulator and result width; legal range >= 2*width.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low, sampled on the clk rising edge.
REQ-006 clr  input  1  synchronous clear of the accumulation in progress.
REQ-007 prod_valid  input  1  one-cycle pulse; the product is present (driven by the multiplier's done flag).
REQ-008 prod  input  2*width  signed product (driven by the multiplier's M output).
REQ-009 res_valid  output  1  result available; held until accepted.
REQ-010 res_ready  input  1  downstream accepts the result.
REQ-011 res  output  ACC_W  signed accumulated result.
REQ-012 busy  output  1  high when 0 < cnt < LEN, i.e. a partial group is held.
REQ-013 ovf  output  1  sticky signed-overflow flag.
REQ-014 drop  output  1  one-cycle pulse when a product is discarded.

Function
REQ-015 The block SHALL implement a two-state FSM: ACC (accumulating) and HOLD (result pending).
REQ-016 In ACC, each prod_valid SHALL add sign-extended prod to acc and increment cnt (0..LEN-1).
REQ-017 In ACC, on prod_valid with cnt==LEN-1, the block SHALL: load res <= acc+prod, set res_valid, zero acc and cnt, and go to HOLD.
REQ-018 res/res_valid SHALL appear one cycle after the final product is sampled; there are no bubbles between products.
REQ-019 In HOLD, res and res_valid SHALL stay stable until res_valid && res_ready; the handshake cycle SHALL return the FSM to ACC and clear res_valid.
REQ-020 In HOLD without res_ready, prod_valid SHALL leave acc and cnt unchanged and pulse drop for one cycle.
REQ-021 In HOLD with res_ready and prod_valid in the same cycle, the product SHALL be accepted as the first of the next group (acc <= prod, cnt <= 1), and drop SHALL stay low.
REQ-022 Signed overflow of any addition SHALL set ovf; ovf SHALL clear only on reset or clr.
REQ-023 clr SHALL zero acc, cnt, res_valid and ovf, and force ACC; it overrides a simultaneous prod_valid or handshake, and res keeps its last value.
REQ-024 Without saturation, the accumulator SHALL wrap modulo 2^ACC_W.

Reset
REQ-025 When rst_n is low at a clk edge: state=ACC, acc=0, cnt=0, res=0, res_valid=0, ovf=0, drop=0; busy therefore reads 0.
REQ-026 Reset mid-group or in HOLD SHALL discard the partial sum and the pending result with no output activity.
REQ-027 Reset SHALL take priority over clr and all other inputs.

Configuration
REQ-028 Macro MULT_ACCUM_SAT_EN: when defined, an overflowing add SHALL clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1), and ovf SHALL still be set.
REQ-029 When MULT_ACCUM_SAT_EN is undefined, the wrap behaviour of REQ-024 applies and no clamp logic is generated.

Structure
REQ-030 A shared package SHALL hold: the FSM state encoding (ST_ACC, ST_HOLD), the default LEN, and a function returning the counter width as clog2(LEN).
REQ-031 One sub-module, acc_sat_add, SHALL implement the signed ACC_W-bit add with overflow detect and the optional clamp; the FSM and handshake live in mult_accum.

Verification (width=8, LEN=4, ACC_W=16 unless stated)
REQ-032 Products 100, -50, 25, 3 on consecutive cycles, res_ready=1 -> res=78 one cycle after the 4th product, res_valid high one cycle, ovf=0.
REQ-033 Four products of 16384 -> res=0 and ovf=1 without the macro; res=32767 and ovf=1 with MULT_ACCUM_SAT_EN.
REQ-034 Result pending, res_ready=0 for 5 cycles, product 7 arrives -> res stable, drop pulses once, and the next group sums without the 7.
REQ-035 In HOLD, res_ready and a product of -9 in the same cycle -> handshake completes, busy=1, and the next result includes -9.
REQ-036 Two products accepted, then clr -> busy=0, ovf=0; the next 4 products 1, 2, 3, 4 -> res=10.
REQ-037 rst_n low for one cycle while in HOLD -> res_valid=0 and res=0 on the next cycle; a subsequent group behaves as REQ-032.
